spi_cmd_decoder: RTL and testbench

- Consumes completed SPI transactions from the SPI receive buffer (4 received bytes plus a done flag in the SCLK/CS domain).
- Synchronizes completion into the system clock domain and decodes the first byte as a command.
- Issues single-byte read/write requests to the system bus arbiter and returns read data to the SPI transmit path.
- Also drives the expected-length input of the SPI buffer and holds one 8-bit control register.

---
 rtl/spi_cmd_pkg.sv | 43 ++++
 rtl/sync_bit.sv | 24 ++
 rtl/spi_cmd_decoder.sv | 188 ++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command decoder: opcodes, lengths,
// FSM encoding and byte-lane offsets into the received SPI word.
package spi_cmd_pkg;

    localparam logic [2:0] OP_WRITE_AT   = 3'b000;
    localparam logic [2:0] OP_READ_AT    = 3'b001;
    localparam logic [2:0] OP_WRITE_NEXT = 3'b010;
    localparam logic [2:0] OP_READ_NEXT  = 3'b011;
    localparam logic [2:0] OP_SET_CTRL   = 3'b100;

    localparam logic [2:0] LEN_WRITE_AT   = 3'd4;
    localparam logic [2:0] LEN_READ_AT    = 3'd3;
    localparam logic [2:0] LEN_WRITE_NEXT = 3'd2;
    localparam logic [2:0] LEN_READ_NEXT  = 3'd1;
    localparam logic [2:0] LEN_SET_CTRL   = 3'd2;
    localparam logic [2:0] LEN_RESERVED   = 3'd1;

    localparam int LANE_CMD = 0;
    localparam int LANE_B1  = 8;
    localparam int LANE_B2  = 16;
    localparam int LANE_B3  = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        BUS    = 2'd2
    } state_e;

    function automatic logic [2:0] op_len(input logic [2:0] op);
        logic [2:0] len;
        len = LEN_RESERVED;
        case (op)
            OP_WRITE_AT:   len = LEN_WRITE_AT;
            OP_READ_AT:    len = LEN_READ_AT;
            OP_WRITE_NEXT: len = LEN_WRITE_NEXT;
            OP_READ_NEXT:  len = LEN_READ_NEXT;
            OP_SET_CTRL:   len = LEN_SET_CTRL;
            default:       len = LEN_RESERVED;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single level signal.
// Ports: clk_i/rst_ni (async low), d_i async input, q_o synchronized level.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes completed SPI transactions into single-byte bus cycles.
// Ports: spi_done/spi_rx_bytes in, spi_length/spi_tx_byte out, bus_* master, ctrl/busy/err status.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  spi_done,
    input  logic [31:0]           spi_rx_bytes,
    output logic [2:0]            spi_length,
    output logic [7:0]            spi_tx_byte,
    output logic                  bus_req,
    input  logic                  bus_ack,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    input  logic [7:0]            bus_rd_data,
    output logic [7:0]            ctrl,
    output logic                  busy,
    output logic                  err
);

    state_e                state_q, state_d;
    logic [31:0]           rx_q, rx_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            tx_q, tx_d;
    logic [7:0]            ctrl_q, ctrl_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] next_q, next_d;
    logic                  done_prev_q;
    logic                  done_sync;
    logic                  strobe;

    logic [2:0]            op;
    logic [7:0]            b1, b2, b3;
    logic [ADDR_WIDTH-1:0] at_wr_addr, at_rd_addr;
    logic                  unused_cmd_bits;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_done_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_reset_n),
        .d_i    (spi_done),
        .q_o    (done_sync)
    );

    assign strobe = done_sync & ~done_prev_q;

    assign spi_length = op_len(spi_rx_bytes[LANE_CMD+5 +: 3]);

    assign op = rx_q[LANE_CMD+5 +: 3];
    assign b1 = rx_q[LANE_B1 +: 8];
    assign b2 = rx_q[LANE_B2 +: 8];
    assign b3 = rx_q[LANE_B3 +: 8];

    // A16 rides in cmd bit 0; the two _AT forms place addr bytes differently.
    assign at_wr_addr = ADDR_WIDTH'({rx_q[LANE_CMD], b2, b3});
    assign at_rd_addr = ADDR_WIDTH'({rx_q[LANE_CMD], b1, b2});

    assign unused_cmd_bits = ^rx_q[LANE_CMD+1 +: 4];

    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tx_d    = tx_q;
        ctrl_d  = ctrl_q;
        busy_d  = busy_q;
        err_d   = err_q;
        next_d  = next_q;

        // Overlapped transaction: dropped, flagged.
        if (strobe && state_q != IDLE) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    rx_d    = spi_rx_bytes;
                    busy_d  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = BUS;
                req_d   = 1'b1;
                case (op)
                    OP_WRITE_AT: begin
                        addr_d  = at_wr_addr;
                        we_d    = 1'b1;
                        wdata_d = b1;
                    end
                    OP_READ_AT: begin
                        addr_d = at_rd_addr;
                        we_d   = 1'b0;
                    end
                    OP_WRITE_NEXT: begin
                        addr_d  = next_q;
                        we_d    = 1'b1;
                        wdata_d = b1;
                    end
                    OP_READ_NEXT: begin
                        addr_d = next_q;
                        we_d   = 1'b0;
                    end
                    OP_SET_CTRL: begin
                        ctrl_d  = b1;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                    default: begin
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
            BUS: begin
                if (bus_ack) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    next_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = IDLE;
                    if (!we_q) begin
                        tx_d = bus_rd_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q     <= IDLE;
            rx_q        <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tx_q        <= '0;
            ctrl_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            next_q      <= '0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tx_q        <= tx_d;
            ctrl_q      <= ctrl_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            next_q      <= next_d;
            done_prev_q <= done_sync;
        end
    end

    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wdata_q;
    assign spi_tx_byte = tx_q;
    assign ctrl        = ctrl_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder against a transaction-level model.
// Ports: none; drives the DUT directly.
module tb_spi_cmd_decoder;

    localparam int AW = 17;
    localparam int SS = 2;

    logic          sys_clk = 1'b0;
    logic          sys_reset_n = 1'b0;
    logic          spi_done = 1'b0;
    logic [31:0]   spi_rx_bytes = '0;
    logic [2:0]    spi_length;
    logic [7:0]    spi_tx_byte;
    logic          bus_req;
    logic          bus_ack = 1'b0;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wr_data;
    logic [7:0]    bus_rd_data = '0;
    logic [7:0]    ctrl;
    logic          busy;
    logic          err;

    spi_cmd_decoder #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_reset_n  (sys_reset_n),
        .spi_done     (spi_done),
        .spi_rx_bytes (spi_rx_bytes),
        .spi_length   (spi_length),
        .spi_tx_byte  (spi_tx_byte),
        .bus_req      (bus_req),
        .bus_ack      (bus_ack),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wr_data  (bus_wr_data),
        .bus_rd_data  (bus_rd_data),
        .ctrl         (ctrl),
        .busy         (busy),
        .err          (err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    int         m_next = 0;
    logic [7:0] m_ctrl = '0;
    logic [7:0] m_tx = '0;
    logic       m_err = 1'b0;
    int         len_tab[8] = '{4, 3, 2, 1, 2, 1, 1, 1};

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        m_next = 0;
        m_ctrl = '0;
        m_tx   = '0;
        m_err  = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input int dly, input logic [7:0] rd);
        int         op;
        int         ea;
        logic       ewe;
        int         k;
        logic       saw_busy;
        logic       saw_req;
        op  = int'(b0[7:5]);
        ewe = (op == 0 || op == 2);
        ea  = m_next;
        if (op == 0) ea = (int'(b0[0]) << 16) | (int'(b2) << 8) | int'(b3);
        if (op == 1) ea = (int'(b0[0]) << 16) | (int'(b1) << 8) | int'(b2);
        spi_rx_bytes = {b3, b2, b1, b0};
        #1;
        n_total++;
        if (spi_length !== 3'(len_tab[op]))
            $display("FAIL length cmd=%h got %0d want %0d", b0, spi_length, len_tab[op]);
        else n_pass++;
        spi_done = 1'b1;
        if (op < 4) begin
            k = 0;
            while (bus_req !== 1'b1 && k < 20) begin
                tick();
                k++;
            end
            spi_done = 1'b0;
            n_total++;
            if (k != SS + 2)
                $display("FAIL latency cmd=%h got %0d want %0d", b0, k, SS + 2);
            else n_pass++;
            for (int i = 0; i <= dly; i++) begin
                n_total++;
                if (bus_req !== 1'b1 || busy !== 1'b1 || bus_addr !== AW'(ea) ||
                    bus_we !== ewe || (ewe && bus_wr_data !== b1))
                    $display("FAIL bus_hold cyc=%0d got req=%b busy=%b a=%h we=%b d=%h want a=%h we=%b d=%h",
                             i, bus_req, busy, bus_addr, bus_we, bus_wr_data, AW'(ea), ewe, b1);
                else n_pass++;
                if (i < dly) tick();
            end
            bus_ack     = 1'b1;
            bus_rd_data = rd;
            tick();
            bus_ack     = 1'b0;
            bus_rd_data = 8'($urandom);
            if (!ewe) m_tx = rd;
            m_next = (ea + 1) % (1 << AW);
            n_total++;
            if (bus_req !== 1'b0 || busy !== 1'b0 || spi_tx_byte !== m_tx)
                $display("FAIL ack_done got req=%b busy=%b tx=%h want 0 0 %h",
                         bus_req, busy, spi_tx_byte, m_tx);
            else n_pass++;
        end else begin
            saw_busy = 1'b0;
            saw_req  = 1'b0;
            repeat (SS + 4) begin
                tick();
                saw_busy |= busy;
                saw_req  |= bus_req;
            end
            spi_done = 1'b0;
            if (op == 4) m_ctrl = b1;
            else m_err = 1'b1;
            n_total++;
            if (saw_req !== 1'b0 || saw_busy !== 1'b1 || busy !== 1'b0 || ctrl !== m_ctrl)
                $display("FAIL nobus cmd=%h got req=%b sawbusy=%b busy=%b ctrl=%h want 0 1 0 %h",
                         b0, saw_req, saw_busy, busy, ctrl, m_ctrl);
            else n_pass++;
        end
        n_total++;
        if (err !== m_err)
            $display("FAIL err cmd=%h got %b want %b", b0, err, m_err);
        else n_pass++;
        repeat (SS + 2) tick();
    endtask

    task automatic test_reset();
        sys_reset_n = 1'b0;
        #3;
        n_total++;
        if (bus_req !== 0 || bus_we !== 0 || busy !== 0 || err !== 0 ||
            bus_addr !== '0 || bus_wr_data !== '0 || spi_tx_byte !== '0 || ctrl !== '0)
            $display("FAIL reset got req=%b we=%b busy=%b err=%b a=%h d=%h tx=%h ctrl=%h want all 0",
                     bus_req, bus_we, busy, err, bus_addr, bus_wr_data, spi_tx_byte, ctrl);
        else n_pass++;
        tick();
        tick();
        sys_reset_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_write_at();
        run_cmd(8'h01, 8'h5A, 8'h80, 8'h00, 2, 8'h00);
        run_cmd(8'h60, 8'h00, 8'h00, 8'h00, 1, 8'h77);
    endtask

    task automatic test_read_at_next();
        run_cmd(8'h20, 8'hE8, 8'h10, 8'h00, 0, 8'hC3);
        run_cmd(8'h60, 8'h00, 8'h00, 8'h00, 0, 8'h3C);
    endtask

    task automatic test_wrap();
        run_cmd(8'h01, 8'h33, 8'hFF, 8'hFF, 0, 8'h00);
        run_cmd(8'h40, 8'h11, 8'h00, 8'h00, 0, 8'h00);
    endtask

    task automatic test_set_ctrl();
        run_cmd(8'h80, 8'hA5, 8'h00, 8'h00, 0, 8'h00);
    endtask

    task automatic test_ack_delays();
        run_cmd(8'h00, 8'h12, 8'h34, 8'h56, 0, 8'h00);
        run_cmd(8'h21, 8'h9A, 8'hBC, 8'h00, 1, 8'h5E);
        run_cmd(8'h40, 8'hEE, 8'h00, 8'h00, 7, 8'h00);
    endtask

    task automatic test_random();
        logic [2:0] op;
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 4));
            run_cmd({op, 5'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 7)), 8'($urandom));
        end
    endtask

    task automatic test_reserved();
        run_cmd(8'hE0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
        run_cmd(8'hA3, 8'h55, 8'h00, 8'h00, 0, 8'h00);
    endtask

    task automatic test_reset_mid_bus();
        int k;
        spi_rx_bytes = {8'h00, 8'h12, 8'h77, 8'h01};
        spi_done = 1'b1;
        k = 0;
        while (bus_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        spi_done = 1'b0;
        #2;
        sys_reset_n = 1'b0;
        #1;
        n_total++;
        if (bus_req !== 0 || bus_we !== 0 || busy !== 0 || err !== 0 ||
            bus_addr !== '0 || bus_wr_data !== '0 || spi_tx_byte !== '0 || ctrl !== '0)
            $display("FAIL reset_mid_bus got req=%b we=%b busy=%b err=%b a=%h d=%h tx=%h ctrl=%h want all 0",
                     bus_req, bus_we, busy, err, bus_addr, bus_wr_data, spi_tx_byte, ctrl);
        else n_pass++;
        tick();
        tick();
        sys_reset_n = 1'b1;
        model_reset();
        tick();
        run_cmd(8'h60, 8'h00, 8'h00, 8'h00, 0, 8'h9D);
    endtask

    task automatic test_overlap();
        int k;
        int reqs;
        spi_rx_bytes = {8'h40, 8'h02, 8'hB7, 8'h00};
        spi_done = 1'b1;
        k = 0;
        while (bus_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        spi_done = 1'b0;
        repeat (SS + 2) tick();
        spi_done = 1'b1;
        repeat (SS + 3) tick();
        spi_done = 1'b0;
        m_err = 1'b1;
        n_total++;
        if (err !== m_err || bus_req !== 1'b1 || bus_addr !== AW'(32'h00240))
            $display("FAIL overlap got err=%b req=%b a=%h want 1 1 00240", err, bus_req, bus_addr);
        else n_pass++;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        m_next = 32'h00241;
        reqs = 0;
        repeat (10) begin
            tick();
            if (bus_req === 1'b1) reqs++;
        end
        n_total++;
        if (reqs != 0)
            $display("FAIL overlap_extra_req got %0d want 0", reqs);
        else n_pass++;
        run_cmd(8'h60, 8'h00, 8'h00, 8'h00, 0, 8'h4B);
    endtask

    initial begin
        test_reset();
        test_write_at();
        test_read_at_next();
        test_wrap();
        test_set_ctrl();
        test_ack_delays();
        test_random();
        test_reserved();
        test_reset_mid_bus();
        test_overlap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
